// File: rtl/tm_credit_pkg.sv
// Shared helpers for the slave-side credit flow-control block: index widths,
// master-id type and error codes.
package tm_credit_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MAX_MASTERS = 256;

  typedef logic [idx_width(MAX_MASTERS)-1:0] master_id_t;

  // Round-robin successor of a master index.
  function automatic master_id_t next_master(input master_id_t id, input int num_masters);
    return (int'(id) == num_masters - 1) ? '0 : id + 1'b1;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVERFLOW,
    ERR_ORPHAN_RSP
  } err_code_e;

endpackage

// File: rtl/tm_credit_fifo.sv
// Synchronous FIFO with full/empty/count; a push while full is accepted only
// when a pop happens in the same cycle.
module tm_credit_fifo
  import tm_credit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_comb begin
    // NOTE: every combinational output is defaulted first, so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; pointers and count define validity, and a reset array could not map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/tm_slave_credit.sv
// Slave-side credit endpoint: per-master request FIFOs, round-robin issue to one
// slave port, in-order response steering. Optional TM_SLAVE_CREDIT_ERR_EN: sticky err.
module tm_slave_credit
  import tm_credit_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_CREDITS = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int RSP_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            req_valid,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] req_data,
  output logic                              slave_req_valid,
  output logic [DATA_WIDTH-1:0]             slave_req_data,
  output logic [idx_width(NUM_MASTERS)-1:0] slave_req_id,
  input  logic                              slave_req_ready,
  input  logic                              slave_rsp_valid,
  input  logic [RSP_WIDTH-1:0]              slave_rsp_data,
  output logic [NUM_MASTERS-1:0]            rsp_valid,
  output logic [RSP_WIDTH-1:0]              rsp_data,
  output logic                              err
);

  localparam int ID_W      = idx_width(NUM_MASTERS);
  localparam int REQ_CNT_W = $clog2(NUM_CREDITS + 1);
  localparam int ORD_DEPTH = NUM_MASTERS * NUM_CREDITS;
  localparam int ORD_CNT_W = $clog2(ORD_DEPTH + 1);

  logic [NUM_MASTERS-1:0]                 req_push, req_pop, req_full, req_empty;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] req_head;
  logic [NUM_MASTERS-1:0][REQ_CNT_W-1:0]  req_count;
  logic [NUM_MASTERS-1:0]                 accept, overflow, cand, bypass;

  logic                  sreq_valid_q, sreq_valid_d;
  logic [DATA_WIDTH-1:0] sreq_data_q, sreq_data_d;
  logic [ID_W-1:0]       sreq_id_q, sreq_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] rsp_valid_q, rsp_valid_d;
  logic [RSP_WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic                  hs, load, win_found;
  logic [ID_W-1:0]       win_idx;
  logic [DATA_WIDTH-1:0] win_data;

  logic                  ord_push, ord_pop, ord_full, ord_empty, ord_overflow;
  logic [ID_W-1:0]       ord_head, rsp_id;
  logic [ORD_CNT_W-1:0]  ord_count;
  logic                  rsp_ok, orphan;

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_req_fifo
    tm_credit_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(NUM_CREDITS)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (req_push[m]),
      .push_data_i(req_data[m*DATA_WIDTH +: DATA_WIDTH]),
      .pop_i      (req_pop[m]),
      .pop_data_o (req_head[m]),
      .full_o     (req_full[m]),
      .empty_o    (req_empty[m]),
      .count_o    (req_count[m])
    );
  end

  assign hs   = sreq_valid_q && slave_req_ready;
  assign load = !sreq_valid_q || hs;

  // A master's credits cover its FIFO entries plus its request held in the output slot.
  always_comb begin
    int  occ;
    logic slot_m;
    occ      = 0;
    slot_m   = 1'b0;
    accept   = '0;
    overflow = '0;
    cand     = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      slot_m      = sreq_valid_q && (sreq_id_q == ID_W'(m));
      occ         = int'(req_count[m]) + (slot_m ? 1 : 0);
      accept[m]   = req_valid[m] && ((occ < NUM_CREDITS) || (hs && slot_m));
      overflow[m] = req_valid[m] && !accept[m];
      cand[m]     = !req_empty[m] || accept[m];
    end
  end

  // An empty FIFO's incoming request goes straight to the output slot when it wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
    win_data = req_empty[win_idx] ? req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH]
                                  : req_head[win_idx];
    bypass  = '0;
    req_pop = '0;
    if (load && win_found) begin
      if (req_empty[win_idx]) bypass[win_idx]  = 1'b1;
      else                    req_pop[win_idx] = 1'b1;
    end
    req_push = accept & ~bypass;
  end

  always_comb begin
    sreq_valid_d = sreq_valid_q;
    sreq_data_d  = sreq_data_q;
    sreq_id_d    = sreq_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (load) begin
      sreq_valid_d = win_found;
      if (win_found) begin
        sreq_data_d = win_data;
        sreq_id_d   = win_idx;
        rr_ptr_d    = ID_W'(next_master(master_id_t'(win_idx), NUM_MASTERS));
      end
    end
  end

  tm_credit_fifo #(.WIDTH(ID_W), .DEPTH(ORD_DEPTH)) u_order_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (ord_push),
    .push_data_i(sreq_id_q),
    .pop_i      (ord_pop),
    .pop_data_o (ord_head),
    .full_o     (ord_full),
    .empty_o    (ord_empty),
    .count_o    (ord_count)
  );

  // A response arriving with an empty order FIFO pairs with the same-cycle handshake.
  assign ord_push     = hs && !(slave_rsp_valid && ord_empty);
  assign ord_pop      = slave_rsp_valid && !ord_empty;
  assign ord_overflow = ord_push && ord_full && !ord_pop;
  assign rsp_id       = ord_empty ? sreq_id_q : ord_head;
  assign rsp_ok       = slave_rsp_valid && (!ord_empty || hs);
  assign orphan       = slave_rsp_valid && !rsp_ok;

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (rsp_ok) begin
      rsp_valid_d[rsp_id] = 1'b1;
      rsp_data_d          = slave_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreq_valid_q <= 1'b0;
      sreq_data_q  <= '0;
      sreq_id_q    <= '0;
      rr_ptr_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      sreq_valid_q <= sreq_valid_d;
      sreq_data_q  <= sreq_data_d;
      sreq_id_q    <= sreq_id_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign slave_req_valid = sreq_valid_q;
  assign slave_req_data  = sreq_data_q;
  assign slave_req_id    = sreq_id_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;

  logic unused_status;
  assign unused_status = ^{req_full, ord_count};

`ifdef TM_SLAVE_CREDIT_ERR_EN
  err_code_e err_code;
  logic      err_q;

  always_comb begin
    err_code = ERR_NONE;
    if ((|overflow) || ord_overflow) err_code = ERR_OVERFLOW;
    else if (orphan)                 err_code = ERR_ORPHAN_RSP;
  end

  always_ff @(posedge clk) begin
    if (rst)                        err_q <= 1'b0;
    else if (err_code != ERR_NONE)  err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = ^{overflow, ord_overflow, orphan};
  assign err        = 1'b0;
`endif

endmodule
